move_scheduler: RTL and testbench

//  Sequences piece movement for the 4x6 scroll grid. Latches button and gravity-tick requests,

---
 rtl/move_scheduler.sv | 172 +++++++++++++++++
 tb/tb_move_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// Piece-movement sequencer for the 4x6 scroll grid: latches button and gravity requests,
// issues one move strobe at a time, and runs the lock handshake. Optional macro: ROUND_ROBIN_EN.
module move_scheduler #(
  parameter int GRAVITY_DIV   = 50_000_000,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic up_en,
  input  logic down_en,
  input  logic left_en,
  input  logic right_en,
  input  logic lock_ack,
  output logic move_up,
  output logic move_down,
  output logic move_left,
  output logic move_right,
  output logic lock_req,
  output logic busy
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRAV_LAST   = CNT_W'(GRAVITY_DIV - 1);

  typedef enum logic [1:0] {IDLE, MOVE, SETTLE, LOCK} state_t;

  // Button vectors are indexed down=0, left=1, right=2, up=3.
  logic [3:0] btnVec;
  logic [3:0] enVec;
  assign btnVec = {btn_up, btn_right, btn_left, btn_down};
  assign enVec  = {up_en, right_en, left_en, down_en};

  state_t           state, stateNext;
  logic [3:0]       pendBtn, pendBtnNext;
  logic             pendG, pendGNext;
  logic [CNT_W-1:0] gravCnt, gravCntNext;
  logic [SET_W-1:0] settleCnt, settleCntNext;
  logic [3:0]       moveReg, moveNext;
  logic             lockReqReg, busyReg;

  logic [3:0] clrBtn;
  logic       clrG;
  logic       flush;
  logic       gravWrap;
  logic       anyBtn;
  logic [1:0] sel;

  assign anyBtn   = |pendBtn;
  assign gravWrap = (state != LOCK) && (gravCnt == GRAV_LAST);

`ifdef ROUND_ROBIN_EN
  // rrPtr names the highest-priority button; the one just granted drops to lowest.
  logic [1:0] rrPtr, rrPtrNext;

  always_comb begin
    logic [1:0] idx;
    sel = 2'd0;
    idx = 2'd0;
    for (int off = 3; off >= 0; off--) begin
      idx = rrPtr + 2'(off);
      if (pendBtn[idx]) sel = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rrPtr <= 2'd0;
    else        rrPtr <= rrPtrNext;
  end
`else
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pendBtn[i]) sel = 2'(i);
    end
  end
`endif

  always_comb begin
    stateNext     = state;
    moveNext      = 4'b0000;
    clrBtn        = 4'b0000;
    clrG          = 1'b0;
    flush         = 1'b0;
    settleCntNext = settleCnt;
`ifdef ROUND_ROBIN_EN
    rrPtrNext     = rrPtr;
`endif
    case (state)
      IDLE: begin
        if (pendG) begin
          clrG = 1'b1;
          if (down_en) begin
            stateNext   = MOVE;
            moveNext[0] = 1'b1;
          end else begin
            stateNext = LOCK;
          end
        end else if (anyBtn) begin
          clrBtn[sel] = 1'b1;
`ifdef ROUND_ROBIN_EN
          rrPtrNext = sel + 2'd1;
`endif
          // A disabled direction silently drops the request.
          if (enVec[sel]) begin
            stateNext     = MOVE;
            moveNext[sel] = 1'b1;
          end
        end
      end
      MOVE: begin
        stateNext     = SETTLE;
        settleCntNext = '0;
      end
      SETTLE: begin
        if (settleCnt == SETTLE_LAST) stateNext = IDLE;
        else                          settleCntNext = settleCnt + 1'b1;
      end
      LOCK: begin
        if (lock_ack) begin
          flush     = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Set beats clear so a press landing on its own grant/flush cycle is kept.
  assign pendBtnNext = (pendBtn & ~clrBtn & {4{~flush}}) | btnVec;
  assign pendGNext   = (pendG & ~clrG & ~flush) | gravWrap;

  always_comb begin
    gravCntNext = gravCnt + 1'b1;
    if (state == LOCK || gravWrap) gravCntNext = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pendBtn    <= 4'b0000;
      pendG      <= 1'b0;
      gravCnt    <= '0;
      settleCnt  <= '0;
      moveReg    <= 4'b0000;
      lockReqReg <= 1'b0;
      busyReg    <= 1'b0;
    end else begin
      state      <= stateNext;
      pendBtn    <= pendBtnNext;
      pendG      <= pendGNext;
      gravCnt    <= gravCntNext;
      settleCnt  <= settleCntNext;
      moveReg    <= moveNext;
      lockReqReg <= (stateNext == LOCK);
      busyReg    <= (stateNext != IDLE);
    end
  end

  assign move_down  = moveReg[0];
  assign move_left  = moveReg[1];
  assign move_right = moveReg[2];
  assign move_up    = moveReg[3];
  assign lock_req   = lockReqReg;
  assign busy       = busyReg;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with GRAVITY_DIV=16, SETTLE_CYCLES=2.
// Cycle 0 is the first clock period after reset release.
module tb_move_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_up, btn_down, btn_left, btn_right;
  logic up_en, down_en, left_en, right_en;
  logic lock_ack;
  logic move_up, move_down, move_left, move_right;
  logic lock_req, busy;

  int nCmp = 0;
  int nErr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  move_scheduler #(.GRAVITY_DIV(16), .SETTLE_CYCLES(2), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .up_en(up_en), .down_en(down_en), .left_en(left_en), .right_en(right_en),
    .lock_ack(lock_ack),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .lock_req(lock_req), .busy(busy)
  );

  // {up,right,left,down}
  function automatic logic [3:0] moves();
    return {move_up, move_right, move_left, move_down};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    {btn_up, btn_down, btn_left, btn_right, lock_ack} = '0;
    {up_en, down_en, left_en, right_en} = 4'b1111;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    {btn_up, btn_down, btn_left, btn_right, lock_ack} = '0;
    {up_en, down_en, left_en, right_en} = 4'b1111;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    nCmp++;
    if ({moves(), lock_req, busy} !== 6'b0) begin
      nErr++;
      $display("FAIL reset_hold got=%b exp=000000", {moves(), lock_req, busy});
    end
    do_reset();
    nCmp++;
    if ({moves(), lock_req, busy} !== 6'b0) begin
      nErr++;
      $display("FAIL reset_release got=%b exp=000000", {moves(), lock_req, busy});
    end
  endtask

  task automatic test_single_left();
    logic [3:0] expM;
    logic       expB;
    do_reset();
    repeat (5) step();
    btn_left = 1'b1;
    step();
    btn_left = 1'b0;
    while (cyc <= 20) begin
      expM = (cyc == 7) ? 4'b0010 : (cyc == 17) ? 4'b0001 : 4'b0000;
      expB = (cyc >= 7 && cyc <= 9) || (cyc >= 17 && cyc <= 19);
      nCmp++;
      if (moves() !== expM) begin
        nErr++;
        $display("FAIL single_left_moves cyc=%0d got=%b exp=%b", cyc, moves(), expM);
      end
      nCmp++;
      if (busy !== expB) begin
        nErr++;
        $display("FAIL single_left_busy cyc=%0d got=%b exp=%b", cyc, busy, expB);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] expM;
    do_reset();
    repeat (5) step();
    btn_left  = 1'b1;
    btn_right = 1'b1;
    step();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    while (cyc <= 15) begin
      expM = (cyc == 7) ? 4'b0010 : (cyc == 11) ? 4'b0100 : 4'b0000;
      nCmp++;
      if (moves() !== expM) begin
        nErr++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, moves(), expM);
      end
      step();
    end
  endtask

  task automatic test_disabled();
    do_reset();
    right_en = 1'b0;
    repeat (5) step();
    btn_right = 1'b1;
    step();
    btn_right = 1'b0;
    while (cyc <= 14) begin
      if (cyc == 8) right_en = 1'b1;  // a stale pend_right would now fire
      nCmp++;
      if ({moves(), busy} !== 5'b0) begin
        nErr++;
        $display("FAIL disabled_drop cyc=%0d got=%b exp=00000", cyc, {moves(), busy});
      end
      step();
    end
  endtask

  task automatic test_lock();
    logic [3:0] expM;
    logic       expL, expB;
    do_reset();
    down_en = 1'b0;
    while (cyc <= 40) begin
      lock_ack = (cyc == 3) || (cyc == 20);
      btn_up   = (cyc == 18);
      if (cyc == 21) down_en = 1'b1;
      expM = (cyc == 38) ? 4'b0001 : 4'b0000;
      expL = (cyc >= 17 && cyc <= 20);
      expB = expL || (cyc >= 38 && cyc <= 40);
      nCmp++;
      if (moves() !== expM) begin
        nErr++;
        $display("FAIL lock_moves cyc=%0d got=%b exp=%b", cyc, moves(), expM);
      end
      nCmp++;
      if (lock_req !== expL) begin
        nErr++;
        $display("FAIL lock_req cyc=%0d got=%b exp=%b", cyc, lock_req, expL);
      end
      nCmp++;
      if (busy !== expB) begin
        nErr++;
        $display("FAIL lock_busy cyc=%0d got=%b exp=%b", cyc, busy, expB);
      end
      step();
    end
    lock_ack = 1'b0;
    btn_up   = 1'b0;
  endtask

  task automatic test_settle_latch();
    logic [3:0] expM;
    do_reset();
    while (cyc <= 14) begin
      btn_left = (cyc == 5);
      btn_up   = (cyc == 8);
      expM = (cyc == 7) ? 4'b0010 : (cyc == 11) ? 4'b1000 : 4'b0000;
      nCmp++;
      if (moves() !== expM) begin
        nErr++;
        $display("FAIL settle_latch cyc=%0d got=%b exp=%b", cyc, moves(), expM);
      end
      step();
    end
    btn_left = 1'b0;
    btn_up   = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] expM;
    do_reset();
    while (cyc < 8) begin
      btn_left = (cyc == 5);
      btn_up   = (cyc == 7);
      step();
    end
    btn_left = 1'b0;
    btn_up   = 1'b0;
    nCmp++;
    if (busy !== 1'b1) begin
      nErr++;
      $display("FAIL settle_busy_before_rst got=%b exp=1", busy);
    end
    rst_n = 1'b0;
    #1;
    nCmp++;
    if ({moves(), lock_req, busy} !== 6'b0) begin
      nErr++;
      $display("FAIL rst_in_settle got=%b exp=000000", {moves(), lock_req, busy});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    while (cyc <= 17) begin
      expM = (cyc == 17) ? 4'b0001 : 4'b0000;
      nCmp++;
      if (moves() !== expM) begin
        nErr++;
        $display("FAIL after_settle_rst cyc=%0d got=%b exp=%b", cyc, moves(), expM);
      end
      step();
    end
    do_reset();
    down_en = 1'b0;
    while (cyc < 18) step();
    nCmp++;
    if (lock_req !== 1'b1) begin
      nErr++;
      $display("FAIL lock_before_rst got=%b exp=1", lock_req);
    end
    rst_n = 1'b0;
    #1;
    nCmp++;
    if ({moves(), lock_req, busy} !== 6'b0) begin
      nErr++;
      $display("FAIL rst_in_lock got=%b exp=000000", {moves(), lock_req, busy});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    while (cyc <= 18) begin
      nCmp++;
      if (lock_req !== (cyc >= 17)) begin
        nErr++;
        $display("FAIL after_lock_rst cyc=%0d got=%b exp=%b", cyc, lock_req, (cyc >= 17));
      end
      step();
    end
  endtask

`ifdef ROUND_ROBIN_EN
  task automatic test_round_robin();
    logic [3:0] expM;
    do_reset();
    while (cyc <= 16) begin
      btn_left  = (cyc == 5) || (cyc == 8);
      btn_right = (cyc == 8);
      expM = (cyc == 7) ? 4'b0010 : (cyc == 11) ? 4'b0100 : (cyc == 15) ? 4'b0010 : 4'b0000;
      nCmp++;
      if (moves() !== expM) begin
        nErr++;
        $display("FAIL round_robin cyc=%0d got=%b exp=%b", cyc, moves(), expM);
      end
      step();
    end
    btn_left  = 1'b0;
    btn_right = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_left();
    test_back_to_back();
    test_disabled();
    test_lock();
    test_settle_latch();
    test_reset_mid();
`ifdef ROUND_ROBIN_EN
    test_round_robin();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
